// File: rtl/uart_tx_frame_if.sv
// Word-level handshake between the upstream producer (TX FIFO / CPU register) and uart_tx_frame.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_frame #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_frame_if.slave  bus,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [BW-1:0]        baud;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 last_stop_clk;
  logic                 accept;

  // The final clock of the last stop bit can already take the next word, giving gapless frames.
  assign last_stop_clk = (state == STOP) && (baud == '0) && (bit_idx == LAST_STOP);
  assign bus.in_ready  = rst_n && ((state == IDLE) || last_stop_clk);
  assign accept        = bus.in_valid && bus.in_ready;

  // Word is captured at accept; the bit being driven always sits in shreg[0].
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= bus.in_data;
    end else if (state == DATA && baud == '0) begin
      shreg <= shreg >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      par_q <= (PARITY_ODD != 0) ? ~^bus.in_data : ^bus.in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      baud       <= '0;
      bit_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= START;
            busy  <= 1'b1;
            baud  <= BAUD_MAX;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud == '0) begin
            state   <= DATA;
            baud    <= BAUD_MAX;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud <= BAUD_MAX;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= par_q;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud == '0) begin
            state   <= STOP;
            baud    <= BAUD_MAX;
            bit_idx <= '0;
            tx      <= 1'b1;
          end else begin
            baud <= baud - 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud == '0) begin
            baud <= BAUD_MAX;
            if (bit_idx == LAST_STOP) begin
              frame_done <= 1'b1;
              bit_idx    <= '0;
              if (accept) begin
                state <= START;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                baud  <= '0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (1 stop bit / even parity, 2 stop bits / odd parity) vs a frame model.
module tb_uart_tx_frame;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FLEN_A = (1 + 8 + P + 1) * CLK_DIV;
  localparam int FLEN_B = (1 + 8 + P + 2) * CLK_DIV;

  typedef bit bitq_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx_a, busy_a, fd_a, tx_b, busy_b, fd_b;
  int   checks = 0;
  int   errors = 0;
  int   acc_a  = 0;
  int   acc_b  = 0;
  bitq_t obs_tx, obs_busy, obs_fd, obs_rdy;

  uart_tx_frame_if #(.DATA_BITS(8)) ifa ();
  uart_tx_frame_if #(.DATA_BITS(8)) ifb ();

  uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .tx(tx_a), .busy(busy_a), .frame_done(fd_a));
  uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .tx(tx_b), .busy(busy_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifa.in_valid && ifa.in_ready) acc_a <= acc_a + 1;
    if (ifb.in_valid && ifb.in_ready) acc_b <= acc_b + 1;
  end

  // Reference: per-clock line level of one frame, built from the frame format.
  function automatic bitq_t model_wave(input logic [7:0] d, input int stop_bits, input bit odd);
    bitq_t bits, q;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^d) ^ odd);
`endif
    for (int i = 0; i < stop_bits; i++) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < CLK_DIV; k++) q.push_back(bits[i]);
    return q;
  endfunction

  function automatic bitq_t busy_exp(input int n, input int busy_len);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back(i < busy_len);
    return q;
  endfunction

  function automatic bitq_t fd_exp(input int n, input int flen, input int nframes);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back(i > 0 && (i % flen) == 0 && (i / flen) <= nframes);
    return q;
  endfunction

  function automatic bitq_t rdy_exp(input int n, input int flen, input int nframes);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back(((i + 1) % flen) == 0 || i >= nframes * flen - 1);
    return q;
  endfunction

  function automatic int first_diff(input bitq_t o, input bitq_t e);
    if (o.size() != e.size()) return (o.size() < e.size()) ? o.size() : e.size();
    foreach (o[i]) if (o[i] !== e[i]) return i;
    return -1;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      ifa.in_valid = v;
      ifa.in_data  = d;
    end else begin
      ifb.in_valid = v;
      ifb.in_data  = d;
    end
  endtask

  task automatic start_word(input int sel, input logic [7:0] d);
    @(negedge clk);
    set_in(sel, 1'b1, d);
    @(posedge clk);
  endtask

  // mode 0: drop valid; mode 1: drop valid and scramble in_data; mode 2: hold valid with 0xAA for one more accept
  task automatic capture(input int sel, input int n, input int mode);
    int acc0 = 0;
    logic [7:0] cur;
    obs_tx.delete(); obs_busy.delete(); obs_fd.delete(); obs_rdy.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_tx.push_back(sel ? tx_b : tx_a);
      obs_busy.push_back(sel ? busy_b : busy_a);
      obs_fd.push_back(sel ? fd_b : fd_a);
      obs_rdy.push_back(sel ? ifb.in_ready : ifa.in_ready);
      cur = sel ? ifb.in_data : ifa.in_data;
      if (mode == 2) begin
        if (i == 0) begin
          acc0 = sel ? acc_b : acc_a;
          set_in(sel, 1'b1, 8'hAA);
        end else if ((sel ? acc_b : acc_a) >= acc0 + 1) begin
          set_in(sel, 1'b0, 8'hAA);
        end
      end else begin
        set_in(sel, 1'b0, (mode == 1) ? 8'($urandom) : cur);
      end
    end
  endtask

  task automatic test_reset();
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({tx_a, busy_a, ifa.in_ready, fd_a} !== 4'b1000) begin
      errors++; $display("FAIL reset_hold_a got %b exp 1000", {tx_a, busy_a, ifa.in_ready, fd_a});
    end
    checks++;
    if ({tx_b, busy_b, ifb.in_ready, fd_b} !== 4'b1000) begin
      errors++; $display("FAIL reset_hold_b got %b exp 1000", {tx_b, busy_b, ifb.in_ready, fd_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_a, busy_a, ifa.in_ready, fd_a} !== 4'b1010) begin
      errors++; $display("FAIL reset_idle_a got %b exp 1010", {tx_a, busy_a, ifa.in_ready, fd_a});
    end
    checks++;
    if ({tx_b, busy_b, ifb.in_ready, fd_b} !== 4'b1010) begin
      errors++; $display("FAIL reset_idle_b got %b exp 1010", {tx_b, busy_b, ifb.in_ready, fd_b});
    end
  endtask

  task automatic test_basic();
    bitq_t e;
    int d;
    int n = FLEN_A + 2;
    start_word(0, 8'hA5);
    capture(0, n, 0);
    e = model_wave(8'hA5, 1, 1'b0);
    e.push_back(1'b1); e.push_back(1'b1);
    d = first_diff(obs_tx, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL basic_tx idx %0d got %0b exp %0b", d, obs_tx[d], e[d]); end
    e = busy_exp(n, FLEN_A);
    d = first_diff(obs_busy, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL basic_busy idx %0d got %0b exp %0b", d, obs_busy[d], e[d]); end
    e = fd_exp(n, FLEN_A, 1);
    d = first_diff(obs_fd, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL basic_done idx %0d got %0b exp %0b", d, obs_fd[d], e[d]); end
    e = rdy_exp(n, FLEN_A, 1);
    d = first_diff(obs_rdy, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL basic_ready idx %0d got %0b exp %0b", d, obs_rdy[d], e[d]); end
  endtask

  task automatic test_parity();
    bitq_t e;
    int d, ones, flen;
    for (int sel = 0; sel < 2; sel++) begin
      flen = sel ? FLEN_B : FLEN_A;
      start_word(sel, 8'h07);
      capture(sel, flen + 2, 0);
      e = model_wave(8'h07, sel ? 2 : 1, sel != 0);
      e.push_back(1'b1); e.push_back(1'b1);
      d = first_diff(obs_tx, e); checks++;
      if (d >= 0) begin errors++; $display("FAIL parity_tx_%0d idx %0d got %0b exp %0b", sel, d, obs_tx[d], e[d]); end
      ones = 0;
      foreach (obs_busy[i]) ones += obs_busy[i];
      checks++;
      if (ones != flen) begin errors++; $display("FAIL parity_len_%0d got %0d exp %0d", sel, ones, flen); end
`ifdef UART_TX_PARITY_EN
      checks++;
      if (obs_tx[9 * CLK_DIV + 1] !== (sel ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL parity_bit_%0d got %0b exp %0b", sel, obs_tx[9 * CLK_DIV + 1], sel ? 1'b0 : 1'b1);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    bitq_t e, w;
    int d;
    int n = 2 * FLEN_B + 2;
    int acc0 = acc_b;
    start_word(1, 8'h55);
    capture(1, n, 2);
    e = model_wave(8'h55, 2, 1'b1);
    w = model_wave(8'hAA, 2, 1'b1);
    foreach (w[i]) e.push_back(w[i]);
    e.push_back(1'b1); e.push_back(1'b1);
    d = first_diff(obs_tx, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_tx idx %0d got %0b exp %0b", d, obs_tx[d], e[d]); end
    e = busy_exp(n, 2 * FLEN_B);
    d = first_diff(obs_busy, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_busy idx %0d got %0b exp %0b", d, obs_busy[d], e[d]); end
    e = fd_exp(n, FLEN_B, 2);
    d = first_diff(obs_fd, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_done idx %0d got %0b exp %0b", d, obs_fd[d], e[d]); end
    e = rdy_exp(n, FLEN_B, 2);
    d = first_diff(obs_rdy, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_ready idx %0d got %0b exp %0b", d, obs_rdy[d], e[d]); end
    checks++;
    if (acc_b - acc0 != 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", acc_b - acc0); end
  endtask

  task automatic test_reset_mid();
    bitq_t e;
    int d;
    bit seen_done = 1'b0;
    logic [7:0] w = 8'($urandom);
    start_word(0, w);
    @(negedge clk);
    set_in(0, 1'b0, w);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_a, busy_a, ifa.in_ready} !== 3'b100) begin
      errors++; $display("FAIL midrst_state got %b exp 100", {tx_a, busy_a, ifa.in_ready});
    end
    repeat (3) begin @(negedge clk); seen_done |= fd_a; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); seen_done |= fd_a; end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %0b exp 0", seen_done); end
    start_word(0, 8'h3C);
    capture(0, FLEN_A + 2, 0);
    e = model_wave(8'h3C, 1, 1'b0);
    e.push_back(1'b1); e.push_back(1'b1);
    d = first_diff(obs_tx, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL midrst_tx idx %0d got %0b exp %0b", d, obs_tx[d], e[d]); end
    e = busy_exp(FLEN_A + 2, FLEN_A);
    d = first_diff(obs_busy, e); checks++;
    if (d >= 0) begin errors++; $display("FAIL midrst_busy idx %0d got %0b exp %0b", d, obs_busy[d], e[d]); end
  endtask

  task automatic test_data_stability();
    bitq_t e;
    int d;
    logic [7:0] w;
    for (int sel = 0; sel < 2; sel++) begin
      w = 8'($urandom);
      start_word(sel, w);
      capture(sel, (sel ? FLEN_B : FLEN_A) + 2, 1);
      e = model_wave(w, sel ? 2 : 1, sel != 0);
      e.push_back(1'b1); e.push_back(1'b1);
      d = first_diff(obs_tx, e); checks++;
      if (d >= 0) begin
        errors++; $display("FAIL stable_tx_%0d word %h idx %0d got %0b exp %0b", sel, w, d, obs_tx[d], e[d]);
      end
    end
  endtask

  task automatic test_random();
    bitq_t e;
    int d, sel, flen;
    logic [7:0] w;
    for (int k = 0; k < 6; k++) begin
      sel  = k % 2;
      flen = sel ? FLEN_B : FLEN_A;
      w    = 8'($urandom);
      start_word(sel, w);
      capture(sel, flen + 2, 0);
      e = model_wave(w, sel ? 2 : 1, sel != 0);
      e.push_back(1'b1); e.push_back(1'b1);
      d = first_diff(obs_tx, e); checks++;
      if (d >= 0) begin
        errors++; $display("FAIL random_tx_%0d word %h idx %0d got %0b exp %0b", k, w, d, obs_tx[d], e[d]);
      end
      e = fd_exp(flen + 2, flen, 1);
      d = first_diff(obs_fd, e); checks++;
      if (d >= 0) begin errors++; $display("FAIL random_done_%0d idx %0d got %0b exp %0b", k, d, obs_fd[d], e[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_data_stability();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
